instr_dispatch_queue: RTL and testbench

//  Buffers DV/host instruction words tagged with a target core and issues them one at a time
//  on the mp_top injection port (instr_valid/instr_word/instr_core_sel/instr_ready).

---
 rtl/instr_dispatch_queue_if.sv | 28 ++
 rtl/instr_dispatch_queue.sv | 147 ++++++++++++++
 tb/tb_instr_dispatch_queue.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_dispatch_queue_if.sv
// rtl/instr_dispatch_queue_if.sv - enqueue and mp_top injection handshake bundle
interface instr_dispatch_queue_if #(
    parameter int CORE_SEL_W = 2
);
    logic                  enq_valid;
    logic [31:0]           enq_word;
    logic [CORE_SEL_W-1:0] enq_core_sel;
    logic                  enq_ready;
    logic                  instr_valid;
    logic [31:0]           instr_word;
    logic [CORE_SEL_W-1:0] instr_core_sel;
    logic                  instr_ready;

    // master: producer plus mp_top; slave: the dispatch queue itself
    modport master (
        output enq_valid, enq_word, enq_core_sel,
        input  enq_ready,
        input  instr_valid, instr_word, instr_core_sel,
        output instr_ready
    );

    modport slave (
        input  enq_valid, enq_word, enq_core_sel,
        output enq_ready,
        output instr_valid, instr_word, instr_core_sel,
        input  instr_ready
    );
endinterface

// File: rtl/instr_dispatch_queue.sv
// rtl/instr_dispatch_queue.sv - show-ahead instruction FIFO feeding the mp_top injection port
module instr_dispatch_queue #(
    parameter int N           = 3,
    parameter int DEPTH       = 8,
    parameter int CORE_SEL_W  = (N <= 1) ? 1 : $clog2(N),
    parameter int STALL_LIMIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    instr_dispatch_queue_if.slave       io,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        bad_sel_err,
    output logic                        stall_err,
    output logic [N-1:0][CNT_W-1:0]     issued_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SC_W  = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {ST_EMPTY, ST_PRESENT, ST_STALLED} state_t;

    typedef struct packed {
        logic [CORE_SEL_W-1:0] sel;
        logic [31:0]           word;
    } entry_t;

    entry_t [DEPTH-1:0]      mem_q, mem_d;
    logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
    logic [SC_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic                    stall_err_q, stall_err_d;
    logic                    bad_sel_q, bad_sel_d;
    logic [N-1:0][CNT_W-1:0] issued_q, issued_d;
    state_t                  state_q, state_d;

    logic           empty;
    logic           full;
    logic           sel_ok;
    logic           enq_fire;
    logic           wr_en;
    logic           pop;
    logic [PTR_W:0] count_d;
    entry_t         head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign sel_ok   = int'(io.enq_core_sel) < N;
    assign enq_fire = io.enq_valid && !full;
    assign wr_en    = enq_fire && sel_ok && !flush;
    assign pop      = !empty && io.instr_ready;

    // Head comes straight from storage: while not empty the head slot is never the write slot,
    // so word/sel cannot move under back-pressure.
    assign head              = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign io.instr_valid    = !empty;
    assign io.instr_word     = empty ? '0 : head.word;
    assign io.instr_core_sel = empty ? '0 : head.sel;
    assign io.enq_ready      = !full;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign bad_sel_err = bad_sel_q;
    assign stall_err   = stall_err_q;
    assign issued_cnt  = issued_q;

    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err_q;
        issued_d    = issued_q;
        state_d     = state_q;
        bad_sel_d   = enq_fire && !sel_ok;

        if (wr_en) begin
            mem_d[wr_ptr_q[PTR_W-1:0]].word = io.enq_word;
            mem_d[wr_ptr_q[PTR_W-1:0]].sel  = io.enq_core_sel;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            issued_d[head.sel] = issued_q[head.sel] + CNT_W'(1);
        end

        count_d = wr_ptr_d - rd_ptr_d;

        if (pop || empty) begin
            stall_cnt_d = '0;
        end else if (stall_cnt_q != SC_W'(STALL_LIMIT)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        case (state_q)
            ST_EMPTY: begin
                if (count_d != '0) state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (count_d == '0) begin
                    state_d = ST_EMPTY;
                end else if (stall_cnt_d == SC_W'(STALL_LIMIT)) begin
                    state_d = ST_STALLED;
                end
            end
            ST_STALLED: begin
                if (pop) state_d = (count_d == '0) ? ST_EMPTY : ST_PRESENT;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (state_q == ST_PRESENT && state_d == ST_STALLED) stall_err_d = 1'b1;

        // Flush drops queue contents and the watchdog, but a same-cycle pop is still counted.
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            stall_cnt_d = '0;
            stall_err_d = 1'b0;
            state_d     = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            stall_cnt_q <= '0;
            stall_err_q <= 1'b0;
            bad_sel_q   <= 1'b0;
            issued_q    <= '0;
            state_q     <= ST_EMPTY;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err_q <= stall_err_d;
            bad_sel_q   <= bad_sel_d;
            issued_q    <= issued_d;
            state_q     <= state_d;
        end
    end
endmodule

// File: tb/tb_instr_dispatch_queue.sv
// tb/tb_instr_dispatch_queue.sv - randomized checks of instr_dispatch_queue against a queue model
module tb_instr_dispatch_queue;
    localparam int N     = 3;
    localparam int DEPTH = 8;
    localparam int SW    = 2;
    localparam int LIMIT = 64;
    localparam int CW    = 6;
    localparam int CMOD  = 1 << CW;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic [$clog2(DEPTH):0] count;
    logic bad_sel_err;
    logic stall_err;
    logic [N-1:0][CW-1:0] issued_cnt;

    always #5 clk = ~clk;

    instr_dispatch_queue_if #(.CORE_SEL_W(SW)) io ();

    instr_dispatch_queue #(
        .N(N), .DEPTH(DEPTH), .CORE_SEL_W(SW), .STALL_LIMIT(LIMIT), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(io.slave),
        .flush(flush),
        .count(count),
        .bad_sel_err(bad_sel_err),
        .stall_err(stall_err),
        .issued_cnt(issued_cnt)
    );

    int total = 0;
    int bad   = 0;

    // reference model: {sel, word} entries in FIFO order
    logic [SW+31:0] mq[$];
    int m_iss[N];
    int m_stall;
    bit m_err;
    bit m_bad;

    task automatic model_reset();
        mq.delete();
        for (int c = 0; c < N; c++) m_iss[c] = 0;
        m_stall = 0;
        m_err   = 1'b0;
        m_bad   = 1'b0;
    endtask

    task automatic model_cycle(input bit ev, input logic [31:0] w, input logic [SW-1:0] s,
                               input bit fl, input bit rdy);
        bit was_full, was_valid, fire, do_pop;
        was_full  = (mq.size() == DEPTH);
        was_valid = (mq.size() != 0);
        fire      = ev && !was_full;
        do_pop    = was_valid && rdy;
        m_bad     = fire && (int'(s) >= N);
        if (do_pop) m_iss[mq[0][SW+31:32]] = (m_iss[mq[0][SW+31:32]] + 1) % CMOD;
        if (fl) begin
            mq.delete();
            m_stall = 0;
            m_err   = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (fire && int'(s) < N) mq.push_back({s, w});
            if (do_pop || !was_valid) begin
                m_stall = 0;
            end else if (m_stall < LIMIT) begin
                m_stall++;
                if (m_stall == LIMIT) m_err = 1'b1;
            end
        end
    endtask

    task automatic drive(input bit ev, input logic [31:0] w, input logic [SW-1:0] s,
                         input bit fl, input bit rdy);
        io.enq_valid    = ev;
        io.enq_word     = w;
        io.enq_core_sel = s;
        flush           = fl;
        io.instr_ready  = rdy;
        model_cycle(ev, w, s, fl, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 32'h0, '0, 1'b0, rdy);
    endtask

    task automatic test_reset();
        io.enq_valid = 1'b0; io.enq_word = '0; io.enq_core_sel = '0;
        io.instr_ready = 1'b0; flush = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (io.instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", io.instr_valid); end
        total++; if (io.instr_word !== 32'h0 || io.instr_core_sel !== '0) begin
            bad++; $display("FAIL reset_head got=%h/%0d exp=0/0", io.instr_word, io.instr_core_sel); end
        total++; if (io.enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready got=%b exp=1", io.enq_ready); end
        total++; if (bad_sel_err !== 1'b0 || stall_err !== 1'b0) begin
            bad++; $display("FAIL reset_errs got=%b%b exp=00", bad_sel_err, stall_err); end
        total++; if (issued_cnt !== '0) begin bad++; $display("FAIL reset_issued got=%h exp=0", issued_cnt); end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h0012_3401, 2'd1, 1'b0, 1'b1);
        total++; if (io.instr_valid !== 1'b1 || io.instr_word !== 32'h0012_3401 || io.instr_core_sel !== 2'd1) begin
            bad++; $display("FAIL single_head got=%b/%h/%0d exp=1/00123401/1", io.instr_valid, io.instr_word, io.instr_core_sel); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
        idle(1'b1);
        total++; if (issued_cnt[1] !== CW'(1)) begin bad++; $display("FAIL single_issued got=%0d exp=1", issued_cnt[1]); end
        total++; if (count !== '0 || io.instr_valid !== 1'b0) begin
            bad++; $display("FAIL single_drain got=%0d/%b exp=0/0", count, io.instr_valid); end
    endtask

    task automatic test_fill_drain();
        logic [31:0] exp_w[DEPTH];
        logic [SW-1:0] exp_s[DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            exp_w[i] = $urandom;
            exp_s[i] = SW'($urandom_range(0, N - 1));
            drive(1'b1, exp_w[i], exp_s[i], 1'b0, 1'b0);
        end
        total++; if (count !== 4'(DEPTH) || io.enq_ready !== 1'b0) begin
            bad++; $display("FAIL full_state got=%0d/%b exp=%0d/0", count, io.enq_ready, DEPTH); end
        drive(1'b1, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0);
        total++; if (count !== 4'(DEPTH) || io.instr_word !== exp_w[0]) begin
            bad++; $display("FAIL ninth_enq got=%0d/%h exp=%0d/%h", count, io.instr_word, DEPTH, exp_w[0]); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (io.instr_valid !== 1'b1 || io.instr_word !== exp_w[i] || io.instr_core_sel !== exp_s[i]) begin
                bad++; $display("FAIL drain_order[%0d] got=%b/%h/%0d exp=1/%h/%0d", i, io.instr_valid,
                                io.instr_word, io.instr_core_sel, exp_w[i], exp_s[i]); end
            idle(1'b1);
        end
        total++; if (io.instr_valid !== 1'b0 || count !== '0) begin
            bad++; $display("FAIL drain_empty got=%b/%0d exp=0/0", io.instr_valid, count); end
    endtask

    task automatic test_bad_sel();
        drive(1'b1, 32'h1234_5678, 2'd3, 1'b0, 1'b1);
        total++; if (bad_sel_err !== 1'b1) begin bad++; $display("FAIL bad_sel_pulse got=%b exp=1", bad_sel_err); end
        total++; if (count !== '0 || io.instr_valid !== 1'b0) begin
            bad++; $display("FAIL bad_sel_dropped got=%0d/%b exp=0/0", count, io.instr_valid); end
        idle(1'b1);
        total++; if (bad_sel_err !== 1'b0) begin bad++; $display("FAIL bad_sel_one_cycle got=%b exp=0", bad_sel_err); end
    endtask

    task automatic test_stall();
        logic [CW-1:0] iss2;
        iss2 = issued_cnt[2];
        drive(1'b1, 32'hCAFE_0002, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < LIMIT - 1; i++) idle(1'b0);
        total++; if (stall_err !== 1'b0) begin bad++; $display("FAIL stall_early got=%b exp=0", stall_err); end
        idle(1'b0);
        total++; if (stall_err !== 1'b1) begin bad++; $display("FAIL stall_trip got=%b exp=1", stall_err); end
        total++; if (io.instr_word !== 32'hCAFE_0002 || io.instr_core_sel !== 2'd2) begin
            bad++; $display("FAIL stall_hold got=%h/%0d exp=cafe0002/2", io.instr_word, io.instr_core_sel); end
        idle(1'b1);
        total++; if (stall_err !== 1'b1 || count !== '0 || issued_cnt[2] !== iss2 + CW'(1)) begin
            bad++; $display("FAIL stall_pop got=%b/%0d/%0d exp=1/0/%0d", stall_err, count, issued_cnt[2], iss2 + CW'(1)); end
        idle(1'b0);
        total++; if (stall_err !== 1'b1) begin bad++; $display("FAIL stall_sticky got=%b exp=1", stall_err); end
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
        total++; if (stall_err !== 1'b0) begin bad++; $display("FAIL stall_flush got=%b exp=0", stall_err); end
    endtask

    task automatic test_flush();
        logic [N-1:0][CW-1:0] iss;
        for (int i = 0; i < 4; i++) drive(1'b1, $urandom, SW'($urandom_range(0, N - 1)), 1'b0, 1'b0);
        total++; if (count !== 4'd4) begin bad++; $display("FAIL flush_pre got=%0d exp=4", count); end
        iss = issued_cnt;
        drive(1'b1, 32'h5555_AAAA, 2'd0, 1'b1, 1'b0);
        total++; if (count !== '0 || io.instr_valid !== 1'b0 || io.enq_ready !== 1'b1) begin
            bad++; $display("FAIL flush_clear got=%0d/%b/%b exp=0/0/1", count, io.instr_valid, io.enq_ready); end
        total++; if (issued_cnt !== iss) begin bad++; $display("FAIL flush_keep_issued got=%h exp=%h", issued_cnt, iss); end
        idle(1'b0);
        total++; if (count !== '0) begin bad++; $display("FAIL flush_enq_dropped got=%0d exp=0", count); end
    endtask

    task automatic test_random();
        bit ev, rdy, pv;
        logic [31:0] w, pw;
        logic [SW-1:0] s, ps;
        logic [N-1:0][CW-1:0] iss0;
        int acc, sum;
        acc  = 0;
        iss0 = issued_cnt;
        for (int c = 0; c < 1000; c++) begin
            ev  = ($urandom_range(0, 3) != 0);
            w   = $urandom;
            s   = ($urandom_range(0, 9) == 0) ? 2'd3 : SW'($urandom_range(0, N - 1));
            rdy = ($urandom_range(0, 1) == 1);
            if (ev && mq.size() != DEPTH && int'(s) < N) acc++;
            pv = io.instr_valid; pw = io.instr_word; ps = io.instr_core_sel;
            drive(ev, w, s, 1'b0, rdy);
            if (pv && !rdy) begin
                total++; if (io.instr_word !== pw || io.instr_core_sel !== ps) begin
                    bad++; $display("FAIL rnd_stable c=%0d got=%h/%0d exp=%h/%0d", c, io.instr_word, io.instr_core_sel, pw, ps); end
            end
            total++; if (count !== 4'(mq.size()) || io.enq_ready !== (mq.size() != DEPTH)) begin
                bad++; $display("FAIL rnd_count c=%0d got=%0d/%b exp=%0d", c, count, io.enq_ready, mq.size()); end
            total++; if (io.instr_valid !== (mq.size() != 0) ||
                         (mq.size() != 0 && {io.instr_core_sel, io.instr_word} !== mq[0])) begin
                bad++; $display("FAIL rnd_head c=%0d got=%b/%0d/%h", c, io.instr_valid, io.instr_core_sel, io.instr_word); end
            total++; if (bad_sel_err !== m_bad || stall_err !== m_err) begin
                bad++; $display("FAIL rnd_errs c=%0d got=%b%b exp=%b%b", c, bad_sel_err, stall_err, m_bad, m_err); end
            for (int k = 0; k < N; k++) begin
                total++; if (issued_cnt[k] !== CW'(m_iss[k])) begin
                    bad++; $display("FAIL rnd_issued[%0d] c=%0d got=%0d exp=%0d", k, c, issued_cnt[k], m_iss[k]); end
            end
        end
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) idle(1'b1);
        total++; if (io.instr_valid !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%b exp=0", io.instr_valid); end
        sum = 0;
        for (int k = 0; k < N; k++) sum += int'(CW'(issued_cnt[k] - iss0[k]));
        total++; if ((sum % CMOD) !== (acc % CMOD)) begin
            bad++; $display("FAIL rnd_issue_sum got=%0d exp=%0d", sum % CMOD, acc % CMOD); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_bad_sel();
        test_stall();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
